// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: MMIO addresses,
// STATUS bit positions and the address-region decoder.
package dmem_pkg;

    localparam logic [31:0] MMIO_CYCLE  = 32'hFFFF_0000;
    localparam logic [31:0] MMIO_TXDATA = 32'hFFFF_0004;
    localparam logic [31:0] MMIO_STATUS = 32'hFFFF_0008;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_ERR     = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;

    typedef enum logic [2:0] {
        REG_RAM      = 3'd0,
        REG_CYCLE    = 3'd1,
        REG_TXDATA   = 3'd2,
        REG_STATUS   = 3'd3,
        REG_UNMAPPED = 3'd4
    } region_e;

    // Byte offset bits are ignored; RAM covers everything below 4 << ram_aw.
    function automatic region_e decode_region(input logic [31:0] a, input int ram_aw);
        region_e r;
        if ((a >> (ram_aw + 32'sd2)) == 32'd0) begin
            r = REG_RAM;
        end else if (a[31:2] == MMIO_CYCLE[31:2]) begin
            r = REG_CYCLE;
        end else if (a[31:2] == MMIO_TXDATA[31:2]) begin
            r = REG_TXDATA;
        end else if (a[31:2] == MMIO_STATUS[31:2]) begin
            r = REG_STATUS;
        end else begin
            r = REG_UNMAPPED;
        end
        return r;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide synchronous FIFO with read/write pointers and an explicit count.
// The head byte reads as zero while the FIFO is empty.
module byte_fifo
    import dmem_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic [7:0]    head
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    mem_q [DEPTH];
    logic          do_push_s;
    logic          do_pop_s;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == {CW{1'b0}});
    assign count     = count_q;
    assign head      = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign do_pop_s  = pop && !empty;
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign do_push_s = push && (!full || do_pop_s);

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are meaningless outside the occupied window.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Load/store slave for the single-cycle core: word RAM plus an MMIO page
// holding a cycle counter, sticky status bits and a byte output stream.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        err
);

    localparam int AW  = $clog2(DEPTH);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]    ram_q [DEPTH];
    logic [31:0]    cycle_q, cycle_d;
    logic           err_q, err_d;
    logic           ovf_q, ovf_d;

    region_e        region_s;
    logic           misaligned_s;
    logic [AW-1:0]  word_idx_s;
    logic           ram_we_s, cycle_we_s, tx_push_s, status_we_s;
    logic           err_set_s, ovf_set_s, pop_s;
    logic           fifo_full_s, fifo_empty_s;
    logic [FCW-1:0] fifo_count_s;
    logic [31:0]    count_ext_s;
    logic [3:0]     occ_s;
    logic [31:0]    status_s;

    assign region_s     = decode_region(addr, AW);
    assign misaligned_s = (addr[1:0] != 2'b00);
    assign word_idx_s   = addr[AW+1:2];
    assign out_valid    = !fifo_empty_s;
    assign pop_s        = out_valid && out_ready;
    assign err          = err_q;

    // Loads never flag errors: addr also carries ordinary ALU results.
    assign err_set_s = memwrite && (misaligned_s || (region_s == REG_UNMAPPED));
    assign ovf_set_s = tx_push_s && fifo_full_s && !pop_s;

    // Store-side decode into per-target write enables.
    always_comb begin
        ram_we_s    = 1'b0;
        cycle_we_s  = 1'b0;
        tx_push_s   = 1'b0;
        status_we_s = 1'b0;
        if (memwrite) begin
            case (region_s)
                REG_RAM:    ram_we_s    = 1'b1;
                REG_CYCLE:  cycle_we_s  = 1'b1;
                REG_TXDATA: tx_push_s   = 1'b1;
                REG_STATUS: status_we_s = 1'b1;
                default:    ram_we_s    = 1'b0;
            endcase
        end else begin
            ram_we_s = 1'b0;
        end
    end

    // Counter and sticky-bit next state; a new set beats a same-cycle W1C.
    always_comb begin
        cycle_d = cycle_q + 32'd1;
        if (cycle_we_s) begin
            cycle_d = writedata;
        end else begin
            cycle_d = cycle_q + 32'd1;
        end
        err_d = err_set_s | (err_q & ~(status_we_s & writedata[ST_ERR]));
        ovf_d = ovf_set_s | (ovf_q & ~(status_we_s & writedata[ST_OVF]));
    end

    // MMIO state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_q <= 32'd0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            cycle_q <= cycle_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    // Word RAM: not reset, so contents survive a mid-run reset.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_q[word_idx_s] <= writedata;
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (tx_push_s),
        .push_data (writedata[7:0]),
        .pop       (pop_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s),
        .head      (out_data)
    );

    assign count_ext_s = 32'(fifo_count_s);
    assign occ_s       = (count_ext_s > 32'd15) ? 4'hF : count_ext_s[3:0];
    assign status_s    = {24'h000000, occ_s, ovf_q, err_q, fifo_empty_s, fifo_full_s};

    // Combinational load mux.
    always_comb begin
        readdata = 32'd0;
        case (region_s)
            REG_RAM:    readdata = ram_q[word_idx_s];
            REG_CYCLE:  readdata = cycle_q;
            REG_TXDATA: readdata = 32'd0;
            REG_STATUS: readdata = status_s;
            default:    readdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM, CYCLE, FIFO stream with a byte
// scoreboard, sticky error/overflow bits and mid-stream reset.
module tb_dmem_responder;

    localparam logic [31:0] A_CYCLE  = 32'hFFFF_0000;
    localparam logic [31:0] A_TX     = 32'hFFFF_0004;
    localparam logic [31:0] A_STATUS = 32'hFFFF_0008;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        err;

    int total = 0;
    int bad = 0;
    logic [7:0] sb [$];

    dmem_responder #(.DEPTH(64), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .memwrite  (memwrite),
        .addr      (addr),
        .writedata (writedata),
        .readdata  (readdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Expected STATUS word for a 4-deep FIFO.
    function automatic logic [31:0] st(input int cnt, input logic e, input logic o);
        logic [3:0] occ;
        occ = (cnt > 15) ? 4'd15 : 4'(cnt);
        return {24'h0, occ, o, e, (cnt == 0), (cnt == 4)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        addr      = a;
        writedata = d;
        step();
        memwrite  = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, readdata, exp);
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!out_valid && sb.size() == 0) break;
            if (out_valid) begin
                if (sb.size() > 0) chk({tag, "_byte"}, {24'h0, out_data}, {24'h0, sb.pop_front()});
                else chk({tag, "_extra"}, {31'd0, out_valid}, 32'd0);
            end
            step();
        end
        out_ready = 1'b0;
        chk({tag, "_left"}, sb.size(), 32'd0);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {24'h0, out_data}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        rd("rst_cycle", A_CYCLE, 32'd0);
        rd("rst_status", A_STATUS, 32'h2);
        reset_n = 1'b1;
        step();

        // RAM
        store(32'h0000_0000, 32'h1111_1111);
        store(32'h0000_0014, 32'h1234_5678);
        store(32'h0000_0010, 32'hDEAD_BEEF);
        rd("ram_10", 32'h10, 32'hDEAD_BEEF);
        rd("ram_14", 32'h14, 32'h1234_5678);
        chk("ram_err", {31'd0, err}, 32'd0);

        // CYCLE load and wrap
        store(A_CYCLE, 32'hFFFF_FFFE);
        rd("cyc_n1", A_CYCLE, 32'hFFFF_FFFE);
        step();
        rd("cyc_n2", A_CYCLE, 32'hFFFF_FFFF);
        step();
        rd("cyc_wrap", A_CYCLE, 32'h0);

        // FIFO overflow: five bytes into four slots
        out_ready = 1'b0;
        for (int b = 0; b < 5; b++) begin
            store(A_TX, 32'h41 + 32'(b));
            if (b < 4) sb.push_back(8'h41 + 8'(b));
        end
        rd("ovf_status", A_STATUS, st(4, 1'b0, 1'b1));
        chk("hold_data0", {24'h0, out_data}, 32'h41);
        step();
        chk("hold_data1", {24'h0, out_data}, 32'h41);
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        drain("ovf_drain");
        rd("ovf_after", A_STATUS, st(0, 1'b0, 1'b1));
        store(A_STATUS, 32'h8);
        rd("ovf_clr", A_STATUS, st(0, 1'b0, 1'b0));

        // Full FIFO with a simultaneous pop and push
        for (int b = 0; b < 4; b++) begin
            store(A_TX, 32'h61 + 32'(b));
            sb.push_back(8'h61 + 8'(b));
        end
        rd("full_status", A_STATUS, st(4, 1'b0, 1'b0));
        out_ready = 1'b1;
        chk("pop_head", {24'h0, out_data}, {24'h0, sb.pop_front()});
        store(A_TX, 32'h5A);
        sb.push_back(8'h5A);
        out_ready = 1'b0;
        rd("pushpop_status", A_STATUS, st(4, 1'b0, 1'b0));
        drain("pp_drain");

        // Access errors and W1C
        store(32'h0000_2000, 32'hCAFE_BABE);
        chk("unmap_err", {31'd0, err}, 32'd1);
        rd("unmap_rd", 32'h0000_2000, 32'd0);
        rd("unmap_ram0", 32'h0, 32'h1111_1111);
        rd("err_status", A_STATUS, st(0, 1'b1, 1'b0));
        store(A_STATUS, 32'h4);
        chk("err_clr", {31'd0, err}, 32'd0);
        store(32'h0000_0013, 32'h0BAD_F00D);
        chk("misal_err", {31'd0, err}, 32'd1);
        rd("misal_ram", 32'h10, 32'h0BAD_F00D);
        store(32'hFFFF_000A, 32'h4);
        chk("set_wins", {31'd0, err}, 32'd1);
        store(A_STATUS, 32'h4);
        chk("err_clr2", {31'd0, err}, 32'd0);
        rd("tx_rd", A_TX, 32'd0);

        // Reset mid-stream
        for (int b = 0; b < 3; b++) begin
            store(A_TX, 32'h71 + 32'(b));
            sb.push_back(8'h71 + 8'(b));
        end
        rd("pre_rst_status", A_STATUS, st(3, 1'b0, 1'b0));
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        reset_n = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_data", {24'h0, out_data}, 32'd0);
        rd("mid_rst_cycle", A_CYCLE, 32'd0);
        rd("mid_rst_status", A_STATUS, 32'h2);
        rd("mid_rst_ram", 32'h10, 32'h0BAD_F00D);
        step();
        reset_n = 1'b1;
        step();
        store(A_TX, 32'h7E);
        sb.push_back(8'h7E);
        drain("post_rst_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the single-cycle MIPS core: the slave end of the datapath's load/store interface (`aluout` as address, `writedata`, `memwrite` from the controller, `readdata` returned). It serves word RAM with combinational read and synchronous write, plus a memory-mapped I/O page with a cycle counter, a status/error register and a byte output FIFO drained over a valid/ready stream. It sits beside the core in the top level, and its stream output feeds a console/UART sink.

## Interface
- `DEPTH`, default 64: RAM size in 32-bit words, power of two, at least 4.
- `FIFO_DEPTH`, default 4: output FIFO entries, power of two, at least 2.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `memwrite`  in  1  store strobe for the current cycle.
- `addr`  in  32  byte address (core ALU result).
- `writedata`  in  32  store data.
- `readdata`  out  32  load data, combinational from `addr`.
- `out_valid`  out  1  FIFO head byte valid.
- `out_ready`  in  1  sink accepts head byte.
- `out_data`  out  8  FIFO head byte.
- `err`  out  1  copy of status bit 2 (sticky access error).

## Operation
- **Address map** (`addr[1:0]` ignored for selection):
  - RAM: `0x0000_0000` to `DEPTH*4-1`. Word index is `addr[clog2(DEPTH)+1:2]`.
  - `0xFFFF_0000` CYCLE (R/W).
  - `0xFFFF_0004` TXDATA (W; reads 0).
  - `0xFFFF_0008` STATUS (R/W1C).
  - Anything else is unmapped.
- **RAM:** read is combinational. Write happens at the posedge when `memwrite=1`. Contents are not reset.
- **CYCLE:** 32-bit counter, +1 every cycle, wraps `0xFFFF_FFFF` to `0`. A write loads `writedata`; the next-cycle value is `writedata`, with no increment that cycle.
- **TXDATA write:** pushes `writedata[7:0]` into the FIFO.
  - Accepted if the FIFO is not full, or if a pop occurs the same cycle.
  - Otherwise the byte is dropped and overflow (bit 3) is set.
- **STATUS read:**
  - bit0 = full, bit1 = empty, bit2 = err, bit3 = overflow.
  - bits[7:4] = occupancy count (saturating display at 15).
  - All other bits are 0.
- **STATUS write:** writing 1 to bit2 or bit3 clears that bit. Other bits are ignored.
- **Access errors:** a misaligned access (`addr[1:0]!=0`) or any access to an unmapped address sets err.
  - "Any access" means `memwrite=1`, or any read-decode cycle? No: only stores set err. Loads are indistinguishable from ALU traffic on `addr`.
  - An unmapped store is ignored. An unmapped read returns 0.
  - A misaligned store to a mapped address still performs the store at the truncated word address.
- **Set/clear priority:** if a clear and a new set of the same sticky bit occur in the same cycle, the set wins.
- **Stream:** a pop occurs when `out_valid && out_ready`. `out_data` is the head byte and is held stable while `out_valid && !out_ready`.

## Timing
- **Reset values:** CYCLE=0, FIFO empty, `out_valid=0`, `out_data=0`, err=0, overflow=0. `readdata` follows `addr` combinationally, so RAM reads return contents and STATUS reads return `0x0000_0002`.
- **Reset mid-operation:** FIFO contents are discarded and RAM contents are kept.
- **Load latency:** 0 cycles. `readdata` is valid in the same cycle as `addr`.
- **Store latency:** visible on a read of the same address in the next cycle.
- **FIFO push latency:** a pushed byte into an empty FIFO gives `out_valid=1` on the next cycle. There is no fall-through in the same cycle.
- **Status reads** reflect the registered state before the current edge.
- **CYCLE read** returns the registered value. A store at cycle N reading back at N+1 returns `writedata`, then `writedata+1` at N+2.

## Structure
- **Package `dmem_pkg`:** address constants `MMIO_CYCLE`, `MMIO_TXDATA`, `MMIO_STATUS`, the STATUS bit-index constants, and an enum for the decoded region (RAM, CYCLE, TXDATA, STATUS, UNMAPPED).
- **Sub-module `byte_fifo`:** synchronous FIFO, width 8, depth `FIFO_DEPTH`.
  - Pointer-based with an explicit count.
  - Ports: push, push_data, pop, full, empty, count, head.
  - Async active-low reset.
- **Top level:** address decode, RAM array, CYCLE register, sticky bits and read mux.

## Test plan
- RAM: store `0xDEADBEEF` at `0x10`, load `0x10` next cycle -> `0xDEADBEEF`. Load `0x14` -> unchanged prior value. `err` stays 0.
- CYCLE: store `0xFFFF_FFFE` to `0xFFFF_0000`. Reads on the following cycles -> `0xFFFF_FFFE`, `0xFFFF_FFFF`, `0x0000_0000`.
- FIFO overflow: `out_ready=0`, store bytes `0x41`..`0x45` to TXDATA.
  - STATUS -> `0x0000_0049` (count 4, full, overflow).
  - Then `out_ready=1` -> `out_data` sequence `0x41`..`0x44`, after which `out_valid=0`.
- Full plus simultaneous pop: FIFO full, `out_ready=1`, store `0x5A` -> accepted, overflow stays 0, count stays 4, `0x5A` emerges last.
- Errors:
  - Store to `0x0000_2000` (unmapped, `DEPTH=64`) -> `err=1`, RAM unchanged, readdata 0.
  - Store to `0x13` -> `err=1`, word `0x10` written.
  - Write `0x4` to STATUS -> `err=0`.
- Reset mid-stream: FIFO holding 3 bytes, assert `reset_n=0` for one cycle -> `out_valid=0`, CYCLE=0, STATUS=`0x2`, and the earlier RAM word still reads back intact.
